// File: rtl/ble_rx_framer_types_pkg.sv
// Shared types for the BLE receive framer: FSM states, error codes and the
// default frame start marker.
package ble_rx_framer_types_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HUNT,
        ST_LEN,
        ST_PAYLOAD,
        ST_CHK,
        ST_DONE,
        ST_ERR
    } rx_framer_state_t;

    typedef enum logic [1:0] {
        RFE_NONE,
        RFE_LEN,
        RFE_CHK,
        RFE_TMO
    } rx_framer_err_t;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

endpackage

// File: rtl/us_timeout_counter.sv
// Microsecond gap timer: a 1 us prescaler feeding a saturating 24-bit counter,
// compared against a programmable limit (limit of 0 never expires).
module us_timeout_counter #(
    parameter int CLK_FREQ_HZ = 50_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        count_en,
    input  logic [23:0] limit,
    output logic        expired
);

    localparam int DIV   = (CLK_FREQ_HZ / 1_000_000 > 0) ? CLK_FREQ_HZ / 1_000_000 : 1;
    localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [PRE_W-1:0] pre_q, pre_d;
    logic [23:0]      us_q, us_d;
    logic             tick;

    assign tick = (pre_q == PRE_W'(DIV - 1));

    always_comb begin
        pre_d = pre_q;
        us_d  = us_q;
        if (clear) begin
            pre_d = '0;
            us_d  = '0;
        end else if (count_en) begin
            if (tick) begin
                pre_d = '0;
                // Saturate so a long stall never wraps back below the limit.
                us_d  = us_q + 24'(us_q != 24'hFF_FFFF);
            end else begin
                pre_d = pre_q + PRE_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q <= '0;
            us_q  <= '0;
        end else begin
            pre_q <= pre_d;
            us_q  <= us_d;
        end
    end

    assign expired = (limit != 24'd0) && (us_q >= limit);

endmodule

// File: rtl/ble_rx_framer.sv
// Pops bytes from the UART RX FIFO, delineates SYNC/LEN/PAYLOAD/CHK frames,
// writes the payload to an external buffer and reports completion or errors.
module ble_rx_framer
    import ble_rx_framer_types_pkg::*;
#(
    parameter int         CLK_FREQ_HZ = 50_000_000,
    parameter int         MAX_LEN     = 64,
    parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEFAULT,
    parameter int         ADDR_W      = $clog2(MAX_LEN)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rd_en,
    input  logic [23:0]       regs_frame_time_count,
    output logic              buf_wr_en,
    output logic [ADDR_W-1:0] buf_wr_addr,
    output logic [7:0]        buf_wr_data,
    output logic              busy,
    output logic              frame_done,
    output logic [7:0]        frame_len,
    output logic              error_pulse,
    output logic [1:0]        error_code,
    output rx_framer_state_t  dbg_state
);

    rx_framer_state_t state_q, state_d;
    rx_framer_err_t   pend_err_q, pend_err_d;
    rx_framer_err_t   err_code_q, err_code_d;
    logic [7:0]       len_q, len_d;
    logic [7:0]       idx_q, idx_d;
    logic [7:0]       chk_q, chk_d;
    logic [7:0]       frame_len_q, frame_len_d;
    logic             in_rx, counting, accept, tmo_expired;

    assign in_rx    = (state_q == ST_HUNT) || (state_q == ST_LEN) ||
                      (state_q == ST_PAYLOAD) || (state_q == ST_CHK);
    assign counting = (state_q == ST_LEN) || (state_q == ST_PAYLOAD) || (state_q == ST_CHK);
    // Handshake: a byte moves only in a cycle where rd_en and rx_valid are both high.
    assign rd_en    = rx_valid && enable && in_rx;
    assign accept   = rd_en;

    us_timeout_counter #(.CLK_FREQ_HZ(CLK_FREQ_HZ)) u_gap_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (accept || !counting),
        .count_en (counting),
        .limit    (regs_frame_time_count),
        .expired  (tmo_expired)
    );

    always_comb begin
        state_d     = state_q;
        pend_err_d  = pend_err_q;
        err_code_d  = err_code_q;
        len_d       = len_q;
        idx_d       = idx_q;
        chk_d       = chk_q;
        frame_len_d = frame_len_q;
        buf_wr_en   = 1'b0;
        case (state_q)
            ST_IDLE: if (enable) state_d = ST_HUNT;
            ST_HUNT: if (accept && rx_data == SYNC_BYTE) begin
                chk_d   = 8'h00;
                state_d = ST_LEN;
            end
            ST_LEN: if (accept) begin
                if (rx_data == 8'd0 || rx_data > 8'(MAX_LEN)) begin
                    pend_err_d = RFE_LEN;
                    state_d    = ST_ERR;
                end else begin
                    len_d   = rx_data;
                    chk_d   = chk_q ^ rx_data;
                    idx_d   = 8'd0;
                    state_d = ST_PAYLOAD;
                end
            end else if (tmo_expired) begin
                pend_err_d = RFE_TMO;
                state_d    = ST_ERR;
            end
            ST_PAYLOAD: if (accept) begin
                buf_wr_en = 1'b1;
                chk_d     = chk_q ^ rx_data;
                idx_d     = idx_q + 8'd1;
                if (idx_q == len_q - 8'd1) state_d = ST_CHK;
            end else if (tmo_expired) begin
                pend_err_d = RFE_TMO;
                state_d    = ST_ERR;
            end
            ST_CHK: if (accept) begin
                if (rx_data == chk_q) begin
                    state_d = ST_DONE;
                end else begin
                    pend_err_d = RFE_CHK;
                    state_d    = ST_ERR;
                end
            end else if (tmo_expired) begin
                pend_err_d = RFE_TMO;
                state_d    = ST_ERR;
            end
            ST_DONE: begin
                frame_len_d = len_q;
                err_code_d  = RFE_NONE;
                state_d     = ST_HUNT;
            end
            ST_ERR: begin
                err_code_d = pend_err_q;
                state_d    = ST_HUNT;
            end
            default: state_d = ST_IDLE;
        endcase
        // Losing the link abandons the frame silently; reported values stay as they were.
        if (!enable) begin
            state_d     = ST_IDLE;
            frame_len_d = frame_len_q;
            err_code_d  = err_code_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            pend_err_q  <= RFE_NONE;
            err_code_q  <= RFE_NONE;
            len_q       <= 8'd0;
            idx_q       <= 8'd0;
            chk_q       <= 8'd0;
            frame_len_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            pend_err_q  <= pend_err_d;
            err_code_q  <= err_code_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            chk_q       <= chk_d;
            frame_len_q <= frame_len_d;
        end
    end

    assign frame_done  = (state_q == ST_DONE) && enable;
    assign error_pulse = (state_q == ST_ERR) && enable;
    assign busy        = (state_q != ST_IDLE) && (state_q != ST_HUNT);
    assign buf_wr_addr = idx_q[ADDR_W-1:0];
    assign buf_wr_data = buf_wr_en ? rx_data : 8'h00;
    assign frame_len   = frame_done ? len_q : frame_len_q;
    assign error_code  = error_pulse ? pend_err_q : (frame_done ? RFE_NONE : err_code_q);
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_ble_rx_framer.sv
// Directed bench for ble_rx_framer: a byte driver feeds the FIFO interface,
// expected buffer writes / completions / errors go into a queue checked by a monitor.
module tb_ble_rx_framer;
    import ble_rx_framer_types_pkg::*;

    localparam int CLK_HZ  = 4_000_000;
    localparam int MAXL    = 64;
    localparam int AW      = $clog2(MAXL);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rd_en;
    logic [23:0]   regs_frame_time_count;
    logic          buf_wr_en;
    logic [AW-1:0] buf_wr_addr;
    logic [7:0]    buf_wr_data;
    logic          busy;
    logic          frame_done;
    logic [7:0]    frame_len;
    logic          error_pulse;
    logic [1:0]    error_code;
    rx_framer_state_t dbg_state;

    int checks = 0;
    int errors = 0;
    logic [17:0] exp_q[$];

    ble_rx_framer #(.CLK_FREQ_HZ(CLK_HZ), .MAX_LEN(MAXL)) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .enable                (enable),
        .rx_data               (rx_data),
        .rx_valid              (rx_valid),
        .rd_en                 (rd_en),
        .regs_frame_time_count (regs_frame_time_count),
        .buf_wr_en             (buf_wr_en),
        .buf_wr_addr           (buf_wr_addr),
        .buf_wr_data           (buf_wr_data),
        .busy                  (busy),
        .frame_done            (frame_done),
        .frame_len             (frame_len),
        .error_pulse           (error_pulse),
        .error_code            (error_code),
        .dbg_state             (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // Expected-event encodings.
    function automatic logic [17:0] ev_wr(input logic [7:0] a, input logic [7:0] d);
        return {2'd1, a, d};
    endfunction
    function automatic logic [17:0] ev_done(input logic [7:0] len);
        return {2'd2, len, 6'd0, 2'd0};
    endfunction
    function automatic logic [17:0] ev_err(input logic [1:0] code);
        return {2'd3, 6'd0, code, 8'd0};
    endfunction

    task automatic mon_compare(input string name, input logic [17:0] act);
        logic [17:0] exp;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s unexpected: got 0x%0h required no event", name, act);
        end else begin
            exp = exp_q.pop_front();
            check(name, 32'(act), 32'(exp));
        end
    endtask

    // monitor
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst_n) begin
                if (buf_wr_en)   mon_compare("buf_write", {2'd1, 8'(buf_wr_addr), buf_wr_data});
                if (frame_done)  mon_compare("frame_done", {2'd2, frame_len, 6'd0, error_code});
                if (error_pulse) mon_compare("error_pulse", {2'd3, 6'd0, error_code, 8'd0});
            end
        end
    end

    // driver: called at a negedge, returns at a negedge after the byte is accepted
    task automatic send_byte(input logic [7:0] b);
        int n;
        rx_data  = b;
        rx_valid = 1'b1;
        n = 0;
        #1;
        while (!rd_en && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!rd_en) begin
            checks++;
            errors++;
            $display("FAIL byte_accept: byte 0x%0h not popped, got rd_en=0 required 1", b);
        end else begin
            @(posedge clk);
        end
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_bytes(input logic [7:0] b[$]);
        foreach (b[i]) send_byte(b[i]);
    endtask

    task automatic wait_drained(input string name, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        enable = 1'b1;
        rx_valid = 1'b1;
        rx_data = 8'hA5;
        regs_frame_time_count = 24'd0;
        #12;
        check("reset_outputs",
              {14'd0, rd_en, buf_wr_en, busy, frame_done, error_pulse, frame_len, error_code, 8'(buf_wr_addr)} |
              {24'd0, buf_wr_data}, 32'd0);
        check("reset_state", 32'(dbg_state), 32'(ST_IDLE));
        rx_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        idle_cycles(2);

        // basic 3-byte frame
        exp_q.push_back(ev_wr(0, 8'h11));
        exp_q.push_back(ev_wr(1, 8'h22));
        exp_q.push_back(ev_wr(2, 8'h33));
        exp_q.push_back(ev_done(3));
        send_bytes('{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03});
        wait_drained("basic_frame_drained", 20);
        check("frame_len_held_3", 32'(frame_len), 32'd3);

        // leading garbage discarded in HUNT
        exp_q.push_back(ev_wr(0, 8'h7E));
        exp_q.push_back(ev_done(1));
        send_bytes('{8'h00, 8'hFF, 8'hA5, 8'h01, 8'h7E, 8'h7F});
        wait_drained("garbage_frame_drained", 20);
        check("frame_len_held_1", 32'(frame_len), 32'd1);

        // checksum error, then recovery
        exp_q.push_back(ev_wr(0, 8'hAA));
        exp_q.push_back(ev_wr(1, 8'hBB));
        exp_q.push_back(ev_err(2'd2));
        send_bytes('{8'hA5, 8'h02, 8'hAA, 8'hBB, 8'h00});
        wait_drained("chk_err_drained", 20);
        check("error_code_held_2", 32'(error_code), 32'd2);
        check("busy_after_err", 32'(busy), 32'd0);
        exp_q.push_back(ev_wr(0, 8'h55));
        exp_q.push_back(ev_done(1));
        send_bytes('{8'hA5, 8'h01, 8'h55, 8'h54});
        wait_drained("recovery_drained", 20);
        check("error_code_cleared", 32'(error_code), 32'd0);

        // bad lengths: zero and MAX_LEN+1
        exp_q.push_back(ev_err(2'd1));
        send_bytes('{8'hA5, 8'h00});
        wait_drained("len0_drained", 20);
        exp_q.push_back(ev_err(2'd1));
        send_bytes('{8'hA5, 8'h41});
        wait_drained("len65_drained", 20);
        check("hunt_after_len_err", 32'(dbg_state), 32'(ST_HUNT));

        // inter-byte timeout: 3 us at 4 cycles/us
        regs_frame_time_count = 24'd3;
        exp_q.push_back(ev_wr(0, 8'h11));
        exp_q.push_back(ev_err(2'd3));
        send_bytes('{8'hA5, 8'h02, 8'h11});
        idle_cycles(8);
        check("tmo_not_early", 32'(exp_q.size()), 32'd1);
        wait_drained("tmo_drained", 30);

        // timeout disabled: same stall, then complete the frame
        regs_frame_time_count = 24'd0;
        exp_q.push_back(ev_wr(0, 8'h11));
        send_bytes('{8'hA5, 8'h02, 8'h11});
        idle_cycles(60);
        check("no_tmo_busy", 32'(busy), 32'd1);
        exp_q.push_back(ev_wr(1, 8'h22));
        exp_q.push_back(ev_done(2));
        send_bytes('{8'h22, 8'h31});
        wait_drained("no_tmo_drained", 20);

        // disable mid-payload
        exp_q.push_back(ev_wr(0, 8'h11));
        send_bytes('{8'hA5, 8'h03, 8'h11});
        rx_data = 8'h22;
        rx_valid = 1'b1;
        enable = 1'b0;
        #1;
        check("disable_rd_en", 32'(rd_en), 32'd0);
        @(posedge clk);
        #1;
        check("disable_state", 32'(dbg_state), 32'(ST_IDLE));
        check("disable_busy", 32'(busy), 32'd0);
        check("disable_rd_en_next", 32'(rd_en), 32'd0);
        idle_cycles(4);
        rx_valid = 1'b0;
        enable = 1'b1;
        idle_cycles(2);
        exp_q.push_back(ev_wr(0, 8'h01));
        exp_q.push_back(ev_wr(1, 8'h02));
        exp_q.push_back(ev_done(2));
        send_bytes('{8'hA5, 8'h02, 8'h01, 8'h02, 8'h01});
        wait_drained("reenable_drained", 20);

        // reset mid-frame after leaving a held error code
        exp_q.push_back(ev_err(2'd1));
        send_bytes('{8'hA5, 8'h00});
        wait_drained("pre_reset_err_drained", 20);
        exp_q.push_back(ev_wr(0, 8'h44));
        send_bytes('{8'hA5, 8'h03, 8'h44});
        rx_data = 8'h55;
        rx_valid = 1'b1;
        rst_n = 1'b0;
        #1;
        check("midframe_reset_outputs",
              {14'd0, rd_en, buf_wr_en, busy, frame_done, error_pulse, frame_len, error_code, 8'(buf_wr_addr)} |
              {24'd0, buf_wr_data}, 32'd0);
        check("midframe_reset_state", 32'(dbg_state), 32'(ST_IDLE));
        @(negedge clk);
        rx_valid = 1'b0;
        rst_n = 1'b1;
        idle_cycles(3);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ble_rx_framer.md
Name: ble_rx_framer

Overview:
- Downstream consumer of the UART RX FIFO once the BLE setup controller hands the link to the processor path (mux_transceiver=1).
- Pops received bytes and delineates frames of the form SYNC(0xA5), LEN, PAYLOAD[LEN], CHK.
- Writes the payload into an external buffer and reports frame completion or a coded error to the processor.
- Supervises inter-byte gaps with an internal microsecond timeout whose count comes from the special registers.

Parameters:
- CLK_FREQ_HZ, 50_000_000, system clock frequency; sets the 1 us prescaler.
- MAX_LEN, 64, largest accepted payload length in bytes (1..255).
- SYNC_BYTE, 8'hA5, frame start marker.
- ADDR_W, $clog2(MAX_LEN), payload buffer address width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  link owned by processor path (mux_transceiver).
- rx_data  in  8  UART o_rx_sys_data.
- rx_valid  in  1  UART o_valid_rx; rx_data holds a byte.
- rd_en  out  1  pop strobe to UART i_rx_fifo_rd_en.
- regs_frame_time_count  in  24  inter-byte timeout in us; 0 disables the timeout.
- buf_wr_en  out  1  payload buffer write strobe.
- buf_wr_addr  out  ADDR_W  payload index.
- buf_wr_data  out  8  payload byte.
- busy  out  1  frame in progress (state not IDLE/HUNT).
- frame_done  out  1  one-cycle pulse: valid frame in buffer.
- frame_len  out  8  length of last valid frame; held until next frame_done.
- error_pulse  out  1  one-cycle pulse on frame error.
- error_code  out  2  0 none, 1 bad length, 2 checksum, 3 timeout; held until next error_pulse or frame_done.

Behaviour:
- Reset: all outputs 0; state IDLE; checksum, counters, and prescaler cleared.
- Byte accept: a byte is consumed in a cycle where rd_en && rx_valid. rd_en = rx_valid && enable && state in {HUNT, LEN, PAYLOAD, CHK}. rx_data is sampled in that same cycle.
- FSM states: IDLE, HUNT, LEN, PAYLOAD, CHK, DONE, ERR.
- IDLE -> HUNT when enable=1.
- HUNT: non-SYNC bytes are popped and discarded silently. SYNC -> LEN; clear chk=0.
- LEN: len==0 or len>MAX_LEN -> ERR(code 1). Otherwise latch len, chk^=len, idx=0 -> PAYLOAD.
- PAYLOAD: each byte drives buf_wr_en=1 combinationally with addr=idx and data=rx_data in the accept cycle. Then chk^=byte, idx++. After byte idx==len-1 -> CHK.
- CHK: byte==chk -> DONE, else ERR(code 2).
- DONE: frame_done=1 and frame_len=len for one cycle, then -> HUNT. Latency is one cycle after the CHK byte is accepted. rd_en=0 in DONE.
- ERR: error_pulse=1 and error_code set for one cycle, then -> HUNT. Bytes received in ERR stay in the FIFO.
- Timeout:
  - Prescaler ticks every CLK_FREQ_HZ/1_000_000 cycles; a us counter increments per tick in LEN, PAYLOAD, and CHK.
  - Prescaler and counter clear on every accepted byte and on entering HUNT.
  - When counter >= regs_frame_time_count (count != 0) -> ERR(code 3).
  - If a byte is accepted in the same cycle the timeout condition becomes true, the byte wins and the counter clears.
  - No timeout in HUNT.
- Disable: enable=0 in any state -> IDLE next cycle. No error, no frame_done, and no rd_en from that cycle on. The partial buffer contents are undefined to the consumer.
- Buffer contents are meaningful only after frame_done. The consumer must not read the buffer while busy=1.
- idx and len arithmetic is 8-bit; idx never exceeds MAX_LEN-1 because LEN was validated.

Decomposition:
- ble_rx_framer_types_pkg holds:
  - FSM enum rx_framer_state_t.
  - error enum rx_framer_err_t {RFE_NONE, RFE_LEN, RFE_CHK, RFE_TMO}.
  - SYNC_BYTE default.
- Sub-module us_timeout_counter: prescaler plus 24-bit us counter with clear/enable/expired. It is reusable by the connection monitor path.

Test Plan:
- Send A5 03 11 22 33 CHK=03^11^22^33=0x03 via UART at 9600 baud, enable=1 -> three buffer writes, addr 0..2 with data 11,22,33; frame_done pulse; frame_len=3; no error_pulse.
- Send 00 FF A5 01 7E 7F -> leading 00, FF discarded; buf[0]=7E; frame_done with frame_len=1.
- Send A5 02 AA BB 00 (expected chk 0x13) -> error_pulse, error_code=2, no frame_done. Then A5 01 55 54 -> frame_done, error_code unchanged until it.
- Send A5 00, and separately A5 41 (65 > MAX_LEN) -> error_pulse with code 1 for each; the framer returns to HUNT.
- regs_frame_time_count = 3 byte periods in us. Send A5 02 11 then stall 5 byte periods -> error_pulse with code 3 about 3 byte periods after the 0x11 stop bit. With count=0 the same stall produces no error.
- Deassert enable mid-PAYLOAD -> rd_en=0 next cycle, state IDLE, no pulses. Re-enable and send a full valid frame -> frame_done. Assert rst_n=0 mid-frame -> all outputs 0 immediately.
